lcd_video_timing_gen: RTL and testbench

LCD_VIDEO_TIMING_GEN -- requirements
Module: lcd_video_timing_gen

---
 rtl/lcd_timing_pkg.sv | 31 +++
 rtl/lcd_pattern_gen.sv | 92 +++++++++
 rtl/lcd_video_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_lcd_video_timing_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared mode codes, colour-bar table and clog2 helper
package lcd_timing_pkg;

    typedef enum logic [2:0] {
        MODE_GRAY   = 3'd0,
        MODE_BAND   = 3'd1,
        MODE_BARS   = 3'd2,
        MODE_SOLID  = 3'd3,
        MODE_STREAM = 3'd4,
        MODE_BLACK5 = 3'd5,
        MODE_BLACK6 = 3'd6,
        MODE_BLACK7 = 3'd7
    } lcd_mode_e;

    localparam int NUM_BARS = 8;

    // {R,G,B} channel-on flags per bar, bar 0 is leftmost; the last bar is black
    localparam logic [2:0] BAR_TABLE [NUM_BARS] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - test pattern / colour selection and stream pixel mux
module lcd_pattern_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 8,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  lcd_mode_e         mode,
    input  logic              active,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [3*CW-1:0]   solid_rgb,
    input  logic [3*CW-1:0]   pix_data,
    input  logic              pix_valid,
    output logic [3*CW-1:0]   rgb
);

    localparam int BAR_W  = H_ACTIVE / NUM_BARS;
    localparam int BAND_H = V_ACTIVE / 3;

    logic [CW-1:0] ramp;
    logic [XW-1:0] bar_cnt_q, bar_cnt_d, cur_cnt;
    logic [2:0]    bar_idx_q, bar_idx_d, cur_idx;
    logic [2:0]    bar_flags;

    generate
        if (XW >= CW) begin : g_ramp_slice
            assign ramp = x[CW-1:0];
        end else begin : g_ramp_pad
            assign ramp = {{(CW-XW){1'b0}}, x};
        end
    endgenerate

    // Bar position tracking: column 0 restarts at bar 0, then step bars every BAR_W pixels; black absorbs the remainder
    always_comb begin
        cur_cnt   = (x == '0) ? '0 : bar_cnt_q;
        cur_idx   = (x == '0) ? '0 : bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (active) begin
            if (cur_idx == 3'(NUM_BARS - 1)) begin
                bar_cnt_d = cur_cnt;
                bar_idx_d = cur_idx;
            end else if (cur_cnt == XW'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = cur_idx + 3'd1;
            end else begin
                bar_cnt_d = cur_cnt + XW'(1);
                bar_idx_d = cur_idx;
            end
        end
        bar_flags = BAR_TABLE[cur_idx];
    end

    // Bar counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Colour selection for the current pixel
    always_comb begin
        rgb = '0;
        case (mode)
            MODE_GRAY:   rgb = {ramp, ramp, ramp};
            MODE_BAND: begin
                if (int'(y) < BAND_H) begin
                    rgb = {ramp, {CW{1'b0}}, {CW{1'b0}}};
                end else if (int'(y) < 2 * BAND_H) begin
                    rgb = {{CW{1'b0}}, ramp, {CW{1'b0}}};
                end else begin
                    rgb = {{CW{1'b0}}, {CW{1'b0}}, ramp};
                end
            end
            MODE_BARS:   rgb = {{CW{bar_flags[2]}}, {CW{bar_flags[1]}}, {CW{bar_flags[0]}}};
            MODE_SOLID:  rgb = solid_rgb;
            MODE_STREAM: rgb = pix_valid ? pix_data : '0;
            default:     rgb = '0;
        endcase
    end

endmodule

// File: rtl/lcd_video_timing_gen.sv
// rtl/lcd_video_timing_gen.sv - LCD raster timing, stream handshake and registered video outputs
module lcd_video_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 215,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 34,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 8,
    parameter int XW       = clog2(H_SYNC + H_BP + H_ACTIVE + H_FP),
    parameter int YW       = clog2(V_SYNC + V_BP + V_ACTIVE + V_FP)
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [2:0]        iDISPLAY_MODE,
    input  logic [3*CW-1:0]   iSOLID_RGB,
    input  logic [3*CW-1:0]   iPIX_DATA,
    input  logic              iPIX_VALID,
    output logic              oPIX_READY,
    output logic              oPIX_SOF,
    input  logic              iCLR_UNDERFLOW,
    output logic              oUNDERFLOW,
    output logic              oHD,
    output logic              oVD,
    output logic              oDEN,
    output logic [CW-1:0]     oLCD_R,
    output logic [CW-1:0]     oLCD_G,
    output logic [CW-1:0]     oLCD_B,
    output logic [XW-1:0]     oLCD_X,
    output logic [YW-1:0]     oLCD_Y,
    output logic              oFRAME_START
);

    localparam int HT      = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT      = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;

    logic [XW-1:0]   h_q, h_d;
    logic [YW-1:0]   v_q, v_d;
    lcd_mode_e       mode_q, mode_d;
    logic            underflow_q, underflow_d;
    logic            hd_q, hd_d, vd_q, vd_d, den_q, den_d;
    logic            frame_start_q, frame_start_d;
    logic [3*CW-1:0] rgb_q, rgb_d, pat_rgb;
    logic [XW-1:0]   x_q, x_d, x_c;
    logic [YW-1:0]   y_q, y_d, y_c;
    logic            frame_top, active, pix_ready;

    // Raster counters and the once-per-frame mode latch
    always_comb begin
        h_d = h_q + XW'(1);
        v_d = v_q;
        if (int'(h_q) == HT - 1) begin
            h_d = '0;
            v_d = (int'(v_q) == VT - 1) ? '0 : v_q + YW'(1);
        end
        frame_top = (h_q == '0) && (v_q == '0);
        mode_d    = frame_top ? lcd_mode_e'(iDISPLAY_MODE) : mode_q;
    end

    // Active window, active coordinates and the stream handshake
    always_comb begin
        active = (int'(h_q) >= H_START) && (int'(h_q) < H_END) &&
                 (int'(v_q) >= V_START) && (int'(v_q) < V_END);
        x_c = XW'(int'(h_q) - H_START);
        y_c = YW'(int'(v_q) - V_START);
        pix_ready = iRST_n && active && (mode_q == MODE_STREAM);
        // A missing pixel sets the flag; setting takes priority over a clear in the same cycle
        if (pix_ready && !iPIX_VALID) begin
            underflow_d = 1'b1;
        end else if (iCLR_UNDERFLOW) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    assign oPIX_READY = pix_ready;
    assign oPIX_SOF   = pix_ready && (x_c == '0) && (y_c == '0);

    lcd_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .mode      (mode_q),
        .active    (active),
        .x         (x_c),
        .y         (y_c),
        .solid_rgb (iSOLID_RGB),
        .pix_data  (iPIX_DATA),
        .pix_valid (iPIX_VALID),
        .rgb       (pat_rgb)
    );

    // Next values of the registered outputs, all derived from the same counter state
    always_comb begin
        hd_d          = (int'(h_q) < H_SYNC) ? HS_POL : ~HS_POL;
        vd_d          = (int'(v_q) < V_SYNC) ? VS_POL : ~VS_POL;
        den_d         = active;
        rgb_d         = active ? pat_rgb : '0;
        x_d           = active ? x_c : '0;
        y_d           = active ? y_c : '0;
        frame_start_d = frame_top;
    end

    // State and output registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= MODE_GRAY;
            underflow_q   <= 1'b0;
            hd_q          <= ~HS_POL;
            vd_q          <= ~VS_POL;
            den_q         <= 1'b0;
            rgb_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            underflow_q   <= underflow_d;
            hd_q          <= hd_d;
            vd_q          <= vd_d;
            den_q         <= den_d;
            rgb_q         <= rgb_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign oUNDERFLOW   = underflow_q;
    assign oHD          = hd_q;
    assign oVD          = vd_q;
    assign oDEN         = den_q;
    assign oLCD_R       = rgb_q[3*CW-1:2*CW];
    assign oLCD_G       = rgb_q[2*CW-1:CW];
    assign oLCD_B       = rgb_q[CW-1:0];
    assign oLCD_X       = x_q;
    assign oLCD_Y       = y_q;
    assign oFRAME_START = frame_start_q;

endmodule

// File: tb/tb_lcd_video_timing_gen.sv
// tb/tb_lcd_video_timing_gen.sv - self-checking bench for lcd_video_timing_gen
module tb_lcd_video_timing_gen;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 1, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int CW = 8, XW = 4, YW = 3;
    localparam int HT = 13, VT = 7;
    localparam int HS0 = H_SYNC + H_BP, VS0 = V_SYNC + V_BP;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic iCLK = 1'b0;
    logic iRST_n;
    logic [2:0] iDISPLAY_MODE;
    logic [23:0] iSOLID_RGB, iPIX_DATA;
    logic iPIX_VALID, iCLR_UNDERFLOW;
    logic oPIX_READY, oPIX_SOF, oUNDERFLOW, oHD, oVD, oDEN, oFRAME_START;
    logic [CW-1:0] oLCD_R, oLCD_G, oLCD_B;
    logic [XW-1:0] oLCD_X;
    logic [YW-1:0] oLCD_Y;

    always #5 iCLK = ~iCLK;

    lcd_video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iDISPLAY_MODE(iDISPLAY_MODE),
        .iSOLID_RGB(iSOLID_RGB), .iPIX_DATA(iPIX_DATA), .iPIX_VALID(iPIX_VALID),
        .oPIX_READY(oPIX_READY), .oPIX_SOF(oPIX_SOF), .iCLR_UNDERFLOW(iCLR_UNDERFLOW),
        .oUNDERFLOW(oUNDERFLOW), .oHD(oHD), .oVD(oVD), .oDEN(oDEN),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
        .oLCD_X(oLCD_X), .oLCD_Y(oLCD_Y), .oFRAME_START(oFRAME_START)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] solid;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    vec_t tab [16];

    int errors = 0;
    int checks = 0;
    int n = 0;
    int fmode = 0;
    bit uf = 1'b0;

    int found, cur_mode, hd_low, vd_low, fs_cnt, den_cnt, first_den, first_fs, last_fs;
    int rdy_cnt, sof_cnt, sof_at, px;
    bit acc;
    logic [23:0] data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (state %0d)", name, got, exp, n);
        end
    endtask

    function automatic logic [23:0] dut_rgb();
        return {oLCD_R, oLCD_G, oLCD_B};
    endfunction

    function automatic logic [23:0] model_rgb(input int m, input int x, input int y,
                                              input logic [23:0] solid, input logic [23:0] pdata,
                                              input bit valid);
        logic [7:0] g;
        int band, bar;
        g = 8'(x);
        case (m)
            0: return {g, g, g};
            1: begin
                band = y / (V_ACTIVE / 3);
                if (band > 2) band = 2;
                return {g, 16'h0} >> (8 * band);
            end
            2: begin
                bar = x / (H_ACTIVE / 8);
                return (bar < 8) ? BARS[bar] : 24'h0;
            end
            3: return solid;
            4: return valid ? pdata : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    // One clock: predict from raster position n, advance, compare at the falling edge
    task automatic cycle();
        int h, v, x, y;
        bit act, rdy;
        logic [23:0] e_rgb;
        logic [2:0] e_sync;
        h = n % HT;
        v = (n / HT) % VT;
        act = (h >= HS0) && (h < HS0 + H_ACTIVE) && (v >= VS0) && (v < VS0 + V_ACTIVE);
        x = act ? h - HS0 : 0;
        y = act ? v - VS0 : 0;
        if (h == 0 && v == 0) fmode = int'(iDISPLAY_MODE);
        rdy = act && (fmode == 4);
        chk("ready_sof", {oPIX_READY, oPIX_SOF}, {rdy, rdy && x == 0 && y == 0});
        e_sync = {h >= H_SYNC, v >= V_SYNC, h == 0 && v == 0};
        e_rgb = act ? model_rgb(fmode, x, y, iSOLID_RGB, iPIX_DATA, iPIX_VALID) : 24'h0;
        if (rdy && !iPIX_VALID) uf = 1'b1;
        else if (iCLR_UNDERFLOW) uf = 1'b0;
        @(posedge iCLK);
        n++;
        @(negedge iCLK);
        chk("sync", {oHD, oVD, oFRAME_START}, e_sync);
        chk("den_xy", {oDEN, oLCD_X, oLCD_Y}, {act, 4'(x), 3'(y)});
        chk("rgb", dut_rgb(), e_rgb);
        chk("underflow", oUNDERFLOW, uf);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sync"}, {oHD, oVD, oFRAME_START}, 3'b110);
        chk({tag, "_ctl"}, {oDEN, oLCD_X, oLCD_Y, oPIX_READY, oPIX_SOF, oUNDERFLOW}, 0);
        chk({tag, "_rgb"}, dut_rgb(), 0);
    endtask

    task automatic wait_frame_start(input string tag);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cycle();
            if (oFRAME_START) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        tab[0]  = '{3'd0, 24'h0, 5, 1, 24'h050505};
        tab[1]  = '{3'd0, 24'h0, 7, 3, 24'h070707};
        tab[2]  = '{3'd2, 24'h0, 0, 0, 24'hFFFFFF};
        tab[3]  = '{3'd2, 24'h0, 1, 0, 24'hFFFF00};
        tab[4]  = '{3'd2, 24'h0, 2, 0, 24'h00FFFF};
        tab[5]  = '{3'd2, 24'h0, 3, 0, 24'h00FF00};
        tab[6]  = '{3'd2, 24'h0, 4, 0, 24'hFF00FF};
        tab[7]  = '{3'd2, 24'h0, 5, 0, 24'hFF0000};
        tab[8]  = '{3'd2, 24'h0, 6, 0, 24'h0000FF};
        tab[9]  = '{3'd2, 24'h0, 7, 0, 24'h000000};
        tab[10] = '{3'd1, 24'h0, 6, 0, 24'h060000};
        tab[11] = '{3'd1, 24'h0, 6, 1, 24'h000600};
        tab[12] = '{3'd1, 24'h0, 6, 2, 24'h000006};
        tab[13] = '{3'd1, 24'h0, 3, 3, 24'h000003};
        tab[14] = '{3'd3, 24'h123456, 2, 2, 24'h123456};
        tab[15] = '{3'd6, 24'h0, 4, 1, 24'h000000};

        iRST_n = 1'b0;
        iDISPLAY_MODE = 3'd0;
        iSOLID_RGB = 24'h0;
        iPIX_DATA = 24'h0;
        iPIX_VALID = 1'b0;
        iCLR_UNDERFLOW = 1'b0;
        repeat (3) @(negedge iCLK);
        chk_reset_outputs("reset");

        // Sync timing and active window over two frames
        iRST_n = 1'b1;
        n = 0;
        uf = 1'b0;
        hd_low = 0; vd_low = 0; fs_cnt = 0; den_cnt = 0; first_den = -1; first_fs = -1; last_fs = -1;
        for (int k = 1; k <= 2 * HT * VT; k++) begin
            cycle();
            if (!oHD) hd_low++;
            if (!oVD) vd_low++;
            if (oFRAME_START) begin
                if (last_fs >= 0) chk("frame_period", k - last_fs, HT * VT);
                if (first_fs < 0) first_fs = k;
                last_fs = k;
                fs_cnt++;
            end
            if (oDEN) begin
                den_cnt++;
                if (first_den < 0) first_den = k;
            end
        end
        chk("hd_low_count", hd_low, 14);
        chk("vd_low_count", vd_low, 26);
        chk("frame_count", fs_cnt, 2);
        chk("first_frame_start", first_fs, 1);
        chk("den_count", den_cnt, 64);
        chk("first_den", first_den, 30);

        // Table-driven pattern checks
        cur_mode = 0;
        for (int i = 0; i < 16; i++) begin
            iDISPLAY_MODE = tab[i].mode;
            iSOLID_RGB = tab[i].solid;
            if (int'(tab[i].mode) != cur_mode) begin
                wait_frame_start("tab_frame_wait");
                cur_mode = int'(tab[i].mode);
            end
            found = 0;
            for (int c = 0; c < 200 && found == 0; c++) begin
                cycle();
                if (oDEN && oLCD_X == 4'(tab[i].x) && oLCD_Y == 3'(tab[i].y)) found = 1;
            end
            chk("tab_pos_wait", found, 1);
            chk($sformatf("tab_rgb[%0d]", i), dut_rgb(), tab[i].rgb);
        end

        // Streaming with counting data
        iDISPLAY_MODE = 3'd4;
        iPIX_VALID = 1'b1;
        wait_frame_start("stream_frame_wait");
        data = 24'h0;
        rdy_cnt = 0; sof_cnt = 0; sof_at = -1;
        for (int k = 0; k < HT * VT; k++) begin
            iPIX_DATA = data;
            acc = oPIX_READY && iPIX_VALID;
            if (oPIX_READY) begin
                rdy_cnt++;
                if (oPIX_SOF) begin
                    sof_cnt++;
                    sof_at = rdy_cnt;
                end
            end
            cycle();
            if (acc) begin
                chk("stream_data", dut_rgb(), data);
                data = data + 24'h1;
            end
        end
        chk("ready_count", rdy_cnt, 32);
        chk("sof_count", sof_cnt, 1);
        chk("sof_first", sof_at, 1);

        // Underflow set, set-beats-clear, clear alone
        chk("uf_idle", oUNDERFLOW, 0);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (oPIX_READY && (n % HT) - HS0 == 5) found = 1;
            else cycle();
        end
        chk("wait_x5", found, 1);
        iPIX_VALID = 1'b0;
        cycle();
        iPIX_VALID = 1'b1;
        chk("uf_set", oUNDERFLOW, 1);
        chk("uf_black", dut_rgb(), 0);
        iPIX_VALID = 1'b0;
        iCLR_UNDERFLOW = 1'b1;
        cycle();
        chk("uf_set_wins", oUNDERFLOW, 1);
        iPIX_VALID = 1'b1;
        cycle();
        iCLR_UNDERFLOW = 1'b0;
        chk("uf_clear", oUNDERFLOW, 0);

        // Re-arm underflow, then reset in the middle of an active line
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (oPIX_READY) found = 1;
            else cycle();
        end
        iPIX_VALID = 1'b0;
        cycle();
        iPIX_VALID = 1'b1;
        chk("uf_rearm", oUNDERFLOW, 1);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cycle();
            if (oDEN && oLCD_X == 4'd3) found = 1;
        end
        chk("wait_midline", found, 1);
        iRST_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        @(posedge iCLK);
        @(negedge iCLK);
        chk_reset_outputs("rst_hold");
        iDISPLAY_MODE = 3'd0;
        iRST_n = 1'b1;
        n = 0;
        uf = 1'b0;
        cycle();
        chk("restart_first", {oFRAME_START, oHD, oVD}, 3'b100);

        // Mode change mid-frame waits for the next frame
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cycle();
            if (oDEN && oLCD_Y == 3'd1) found = 1;
        end
        chk("wait_mid_frame", found, 1);
        iDISPLAY_MODE = 3'd3;
        iSOLID_RGB = 24'hABCDEF;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cycle();
            if (oFRAME_START) found = 1;
            else if (oDEN) begin
                px = ((n - 1) % HT) - HS0;
                chk("latch_gray", dut_rgb(), {8'(px), 8'(px), 8'(px)});
            end
        end
        chk("wait_next_frame", found, 1);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cycle();
            if (oDEN) found = 1;
        end
        chk("wait_solid", found, 1);
        chk("latch_solid", dut_rgb(), 24'hABCDEF);

        // Randomized inputs across several frames, checked by the reference model
        for (int f = 0; f < 6; f++) begin
            case (f)
                0: iDISPLAY_MODE = 3'd4;
                1: iDISPLAY_MODE = 3'd1;
                2: iDISPLAY_MODE = 3'd2;
                3: iDISPLAY_MODE = 3'd4;
                4: iDISPLAY_MODE = 3'd3;
                default: iDISPLAY_MODE = 3'(($urandom_range(0, 7)));
            endcase
            for (int k = 0; k < HT * VT; k++) begin
                iPIX_VALID = ($urandom_range(0, 3) != 0);
                iCLR_UNDERFLOW = ($urandom_range(0, 7) == 0);
                iPIX_DATA = 24'($urandom);
                iSOLID_RGB = 24'($urandom);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
